game_move_seq: RTL and testbench
================================

# game_move_seq

Control sequencer for the track-runner game datapath. It accepts the 64-column obstacle map, one column per cycle over a 4-lane bus, and writes each column into the map buffer. It then starts the path solver, waits for completion, and streams the solver's 63 moves on `out`/`out_valid`. It also guards the output protocol: it tracks the runner's lane and masks any move that would leave lanes 0..3.

## Interface
- `COLS`, 64: map columns per game; the move count is COLS-1.
- `TIMEOUT`, 2048: maximum cycles spent in WAIT before the game is aborted.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  map column valid.
- `init`  in  2  starting lane; sampled only on the first in_valid cycle.
- `in0`..`in3`  in  2 each  cell codes for lanes 0..3: 0 road, 1 low obstacle, 2 high obstacle, 3 train.
- `map_we`  out  1  map buffer write enable (combinational).
- `map_addr`  out  6  column address (combinational).
- `map_wdata`  out  8  {in3,in2,in1,in0} (combinational).
- `solve_start`  out  1  one-cycle pulse to the solver.
- `solve_init`  out  2  registered starting lane; held stable from SOLVE until the next game starts.
- `solve_done`  in  1  solver finished; sampled only in WAIT.
- `mv_addr`  out  6  move buffer read address (combinational).
- `mv_data`  in  2  move at mv_addr, valid in the same cycle: 0 forward, 1 lane+1, 2 lane-1, 3 jump.
- `out_valid`  out  1  registered; high for exactly COLS-1 consecutive cycles per game.
- `out`  out  2  registered move; 0 whenever out_valid is 0.
- `err`  out  1  registered one-cycle error pulse.

## Operation
- FSM states: IDLE, LOAD, SOLVE, WAIT, OUT.
- IDLE:
  - When in_valid=1: write column 0, capture init into `solve_init` and `lane`, set col_cnt=1, go to LOAD.
- LOAD:
  - Each in_valid cycle writes column col_cnt, then col_cnt increments.
  - Writing column COLS-1 moves the FSM to SOLVE.
  - in_valid=0 before column COLS-1: pulse err, go to IDLE; buffer contents are don't-care.
- SOLVE:
  - solve_start=1 for this single cycle.
  - Next state is WAIT; the wait counter clears to 0.
- WAIT:
  - solve_done=1: go to OUT, mv_idx=0.
  - Otherwise the wait counter increments.
  - Counter reaches TIMEOUT-1 with no done: pulse err, go to IDLE. No out_valid is issued.
- OUT:
  - mv_addr=mv_idx.
  - At each edge, latch out from mv_data, increment mv_idx, and update lane.
  - mv_idx=COLS-2 moves the FSM to IDLE at the same edge.
- Lane guard, applied per latched move:
  - Move 1 with lane=3, or move 2 with lane=0: latch out=0 instead, leave lane unchanged, pulse err.
  - Otherwise lane follows the move.
- map_we = in_valid in IDLE or LOAD only; map_addr = col_cnt (0 in IDLE).
- in_valid=1 in SOLVE, WAIT or OUT: input ignored, no write, err pulses once on the rising cycle. The current game continues.

## Timing
- Reset values: state=IDLE, col_cnt=0, mv_idx=0, lane=0, solve_init=0, out_valid=0, out=0, err=0.
- Reset mid-operation returns to IDLE immediately and clears all outputs. The solver is not notified.
- Input phase: the last column arrives in cycle C.
- Solver handshake:
  - solve_start is high in C+1.
  - The earliest solve_done is seen in C+2.
  - The FSM is in OUT from C+3.
- Output phase:
  - First out_valid is in C+4; input-to-output latency is at least 4 cycles.
  - out_valid is high for cycles C+4 .. C+66 when done arrives immediately.
  - out_valid falls to 0 with out=0 at the following edge.
- A new game's in_valid is accepted in IDLE in the cycle immediately after OUT ends.
- solve_done high outside WAIT is ignored.
- Counter widths: col_cnt and mv_idx are 6 bits; the wait counter is 11 bits at the default TIMEOUT. None of them wraps within a game.

## Test plan
- Normal game:
  - Stimulus: init=2, 64 columns, solver returns done 5 cycles after start, move buffer holds all 0.
  - Response: map_we is seen on 64 cycles with addresses 0..63; solve_start pulses exactly once; out_valid is high for 63 cycles; out=0 throughout; err is never set.
- Lane guard:
  - Stimulus: init=3, mv_data[0]=1, mv_data[1]=2.
  - Response: first out=0 with an err pulse; second out=2; lane ends at 2.
- Timeout:
  - Stimulus: solve_done held 0.
  - Response: err pulses in cycle C+2+TIMEOUT; out_valid never rises; the next game is accepted.
- Short load:
  - Stimulus: in_valid drops after 10 columns.
  - Response: err pulses; no solve_start; state returns to IDLE.
- Reset mid-OUT:
  - Stimulus: rst_n low during move 20.
  - Response: out_valid=0 and out=0 immediately; a back-to-back new game then runs cleanly.
- Spurious in_valid:
  - Stimulus: in_valid=1 for 3 cycles during WAIT.
  - Response: map_we stays 0; err pulses once; the game completes with 63 outputs.

Source files
------------

// File: rtl/game_move_seq_if.sv
// game_move_seq_if: map input, solver handshake, move buffer and output bus of the move sequencer.
interface game_move_seq_if #(parameter int COLS = 64);
  localparam int AW = $clog2(COLS);
  logic          in_valid;
  logic [1:0]    init, in0, in1, in2, in3;
  logic          map_we;
  logic [AW-1:0] map_addr;
  logic [7:0]    map_wdata;
  logic          solve_start;
  logic [1:0]    solve_init;
  logic          solve_done;
  logic [AW-1:0] mv_addr;
  logic [1:0]    mv_data;
  logic          out_valid;
  logic [1:0]    out;
  logic          err;
  modport master (
    output in_valid, init, in0, in1, in2, in3, solve_done, mv_data,
    input  map_we, map_addr, map_wdata, solve_start, solve_init, mv_addr, out_valid, out, err
  );
  modport slave (
    input  in_valid, init, in0, in1, in2, in3, solve_done, mv_data,
    output map_we, map_addr, map_wdata, solve_start, solve_init, mv_addr, out_valid, out, err
  );
endinterface

// File: rtl/game_move_seq.sv
// game_move_seq: loads the obstacle map, runs the path solver, streams its moves
// with a lane guard that masks moves leaving lanes 0..3.
module game_move_seq #(
  parameter int COLS    = 64,
  parameter int TIMEOUT = 2048
) (
  input logic           clk,
  input logic           rst_n,
  game_move_seq_if.slave bus
);
  localparam int AW = $clog2(COLS);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [AW-1:0] LAST_COL  = AW'(COLS - 1);
  localparam logic [AW-1:0] LAST_MV   = AW'(COLS - 2);
  localparam logic [WW-1:0] LAST_WAIT = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SOLVE, WAIT, OUT} state_t;

  state_t        state_q;
  logic [AW-1:0] col_cnt_q, mv_idx_q;
  logic [WW-1:0] wait_cnt_q;
  logic [1:0]    lane_q, init_q, out_q;
  logic          out_valid_q, err_q, start_q, in_valid_q;
  logic          busy, spur, blocked;
  logic [1:0]    lane_d;

  // in_valid outside the load phase is flagged only on its rising cycle
  assign busy    = state_q inside {SOLVE, WAIT, OUT};
  assign spur    = busy & bus.in_valid & ~in_valid_q;
  assign blocked = (bus.mv_data == 2'd1 && lane_q == 2'd3) || (bus.mv_data == 2'd2 && lane_q == 2'd0);
  assign lane_d  = blocked              ? lane_q :
                   bus.mv_data == 2'd1  ? lane_q + 2'd1 :
                   bus.mv_data == 2'd2  ? lane_q - 2'd1 : lane_q;

  assign bus.map_we      = bus.in_valid & (state_q == IDLE || state_q == LOAD);
  assign bus.map_addr    = state_q == IDLE ? '0 : col_cnt_q;
  assign bus.map_wdata   = {bus.in3, bus.in2, bus.in1, bus.in0};
  assign bus.solve_start = start_q;
  assign bus.solve_init  = init_q;
  assign bus.mv_addr     = mv_idx_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out         = out_q;
  assign bus.err         = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_cnt_q   <= '0;
      mv_idx_q    <= '0;
      wait_cnt_q  <= '0;
      lane_q      <= 2'd0;
      init_q      <= 2'd0;
      out_q       <= 2'd0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      in_valid_q  <= 1'b0;
    end else begin
      in_valid_q  <= bus.in_valid;
      err_q       <= spur;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= 2'd0;
      case (state_q)
        IDLE: if (bus.in_valid) begin
          init_q    <= bus.init;
          lane_q    <= bus.init;
          col_cnt_q <= AW'(1);
          state_q   <= LOAD;
        end
        LOAD: if (!bus.in_valid) begin
          err_q   <= 1'b1;
          state_q <= IDLE;
        end else if (col_cnt_q == LAST_COL) begin
          col_cnt_q <= '0;
          start_q   <= 1'b1;
          state_q   <= SOLVE;
        end else begin
          col_cnt_q <= col_cnt_q + 1'b1;
        end
        SOLVE: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: if (bus.solve_done) begin
          mv_idx_q <= '0;
          state_q  <= OUT;
        end else if (wait_cnt_q == LAST_WAIT) begin
          err_q   <= 1'b1;
          state_q <= IDLE;
        end else begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
        end
        OUT: begin
          out_valid_q <= 1'b1;
          out_q       <= blocked ? 2'd0 : bus.mv_data;
          err_q       <= spur | blocked;
          lane_q      <= lane_d;
          mv_idx_q    <= mv_idx_q == LAST_MV ? '0 : mv_idx_q + 1'b1;
          if (mv_idx_q == LAST_MV) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_game_move_seq.sv
// tb_game_move_seq: directed games against a behavioural solver and move buffer.
module tb_game_move_seq;
  localparam int COLS = 64, TIMEOUT = 2048;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  game_move_seq_if #(.COLS(COLS)) bus ();
  game_move_seq #(.COLS(COLS), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  logic [1:0] mv_mem [COLS];
  assign bus.mv_data = mv_mem[bus.mv_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  int we_cnt, addr_bad, wd_bad, inv_bad;
  int ssc[$], ovc[$], errc[$];
  logic [1:0] outs[$];
  bit solver_en = 1'b1;
  int done_dly = 1;
  int c_last, c0, c1, c2, c3, c4, c5, c6, c7, c8, nz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] col_data(input int c);
    return {2'(c + 3), 2'(c * 3 + 2), 2'(c + 1), 2'(c)};
  endfunction

  always @(negedge clk) if (rst_n) begin
    if (bus.map_we) begin
      if (int'(bus.map_addr) != we_cnt % COLS) addr_bad++;
      if (bus.map_wdata != col_data(int'(bus.map_addr))) wd_bad++;
      we_cnt++;
    end
    if (bus.solve_start) ssc.push_back(cyc);
    if (bus.out_valid) begin
      ovc.push_back(cyc);
      outs.push_back(bus.out);
    end else if (bus.out != 2'd0) inv_bad++;
    if (bus.err) errc.push_back(cyc);
  end

  initial begin
    bus.solve_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.solve_start && solver_en) begin
        repeat (done_dly) @(posedge clk);
        #1 bus.solve_done = 1'b1;
        @(posedge clk);
        #1 bus.solve_done = 1'b0;
      end
    end
  end

  task automatic clear();
    we_cnt = 0; addr_bad = 0; wd_bad = 0; inv_bad = 0;
    ssc.delete(); ovc.delete(); errc.delete(); outs.delete();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int t);
    while (cyc < t) next();
  endtask

  task automatic fill_mv(input logic [1:0] v);
    for (int i = 0; i < COLS; i++) mv_mem[i] = v;
  endtask

  task automatic send(input logic [1:0] ini, input int n);
    for (int c = 0; c < n; c++) begin
      bus.in_valid = 1'b1;
      bus.init = c == 0 ? ini : ~ini;
      {bus.in3, bus.in2, bus.in1, bus.in0} = col_data(c);
      c_last = cyc;
      next();
    end
    bus.in_valid = 1'b0;
  endtask

  function automatic int count_not(input logic [1:0] v);
    int n = 0;
    foreach (outs[i]) if (outs[i] != v) n++;
    return n;
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.init = 2'd0;
    {bus.in3, bus.in2, bus.in1, bus.in0} = 8'd0;
    fill_mv(2'd0);
    clear();
    repeat (2) next();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out", bus.out, 0);
    check("rst_err", bus.err, 0);
    check("rst_solve_start", bus.solve_start, 0);
    check("rst_solve_init", bus.solve_init, 0);
    check("rst_map_addr", bus.map_addr, 0);
    check("rst_mv_addr", bus.mv_addr, 0);
    rst_n = 1'b1;
    next();

    // normal game, done 5 cycles after start
    done_dly = 5; send(2'd2, COLS); c0 = c_last; goto(c0 + 80);
    check("norm_we_cnt", we_cnt, 64);
    check("norm_addr_bad", addr_bad, 0);
    check("norm_wdata_bad", wd_bad, 0);
    check("norm_start_cnt", ssc.size(), 1);
    check("norm_start_cyc", ssc[0], c0 + 1);
    check("norm_ov_cnt", ovc.size(), 63);
    check("norm_ov_first", ovc[0], c0 + 8);
    check("norm_ov_last", ovc[62], c0 + 70);
    check("norm_out_nonzero", count_not(2'd0), 0);
    check("norm_err_cnt", errc.size(), 0);
    check("norm_out_idle", inv_bad, 0);
    check("norm_solve_init", bus.solve_init, 2);

    // lane guard, then a game started right after OUT ends
    clear(); mv_mem[0] = 2'd1; mv_mem[1] = 2'd2; mv_mem[2] = 2'd1; mv_mem[3] = 2'd1;
    done_dly = 1; send(2'd3, COLS); c1 = c_last; goto(c1 + 66);
    fill_mv(2'd0);
    send(2'd1, COLS); c2 = c_last; goto(c2 + 70);
    check("lane_out0", outs[0], 0);
    check("lane_out1", outs[1], 2);
    check("lane_out2", outs[2], 1);
    check("lane_out3", outs[3], 0);
    check("lane_err_cnt", errc.size(), 2);
    check("lane_err0_cyc", errc[0], c1 + 4);
    check("lane_err1_cyc", errc[1], c1 + 7);
    check("lane_ov_first", ovc[0], c1 + 4);
    check("lane_ov_last", ovc[62], c1 + 66);
    check("b2b_ov_total", ovc.size(), 126);
    check("b2b_ov_first", ovc[63], c2 + 4);
    check("b2b_we_cnt", we_cnt, 128);
    check("b2b_addr_bad", addr_bad, 0);
    check("b2b_start_cnt", ssc.size(), 2);
    check("b2b_solve_init", bus.solve_init, 1);
    check("b2b_out_idle", inv_bad, 0);

    // solver never answers
    clear(); solver_en = 1'b0; send(2'd0, COLS); c3 = c_last; goto(c3 + TIMEOUT + 10);
    check("to_err_cnt", errc.size(), 1);
    check("to_err_cyc", errc[0], c3 + 2 + TIMEOUT);
    check("to_ov_cnt", ovc.size(), 0);
    check("to_start_cnt", ssc.size(), 1);
    clear(); solver_en = 1'b1; done_dly = 3; send(2'd1, COLS); c4 = c_last; goto(c4 + 75);
    check("after_to_ov_cnt", ovc.size(), 63);
    check("after_to_ov_first", ovc[0], c4 + 6);
    check("after_to_err_cnt", errc.size(), 0);

    // in_valid drops after 10 columns
    clear(); send(2'd2, 10); c5 = c_last; goto(c5 + 20);
    check("short_err_cnt", errc.size(), 1);
    check("short_err_cyc", errc[0], c5 + 2);
    check("short_start_cnt", ssc.size(), 0);
    check("short_we_cnt", we_cnt, 10);

    // spurious in_valid for 3 cycles during WAIT
    clear(); done_dly = 20; send(2'd1, COLS); c6 = c_last; goto(c6 + 5);
    bus.in_valid = 1'b1; repeat (3) next(); bus.in_valid = 1'b0;
    goto(c6 + 100);
    check("spur_we_cnt", we_cnt, 64);
    check("spur_err_cnt", errc.size(), 1);
    check("spur_err_cyc", errc[0], c6 + 6);
    check("spur_ov_cnt", ovc.size(), 63);
    check("spur_ov_first", ovc[0], c6 + 23);

    // reset during move 20, then a fresh game
    clear(); fill_mv(2'd3); done_dly = 1; send(2'd0, COLS); c7 = c_last; goto(c7 + 24);
    check("mid_out_valid", bus.out_valid, 1);
    check("mid_out", bus.out, 3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_out", bus.out, 0);
    check("rst_mid_err", bus.err, 0);
    next(); next();
    rst_n = 1'b1;
    clear(); send(2'd2, COLS); c8 = c_last; goto(c8 + 70);
    check("post_rst_we_cnt", we_cnt, 64);
    check("post_rst_start_cnt", ssc.size(), 1);
    check("post_rst_ov_cnt", ovc.size(), 63);
    check("post_rst_ov_first", ovc[0], c8 + 4);
    check("post_rst_out_not3", count_not(2'd3), 0);
    check("post_rst_err_cnt", errc.size(), 0);
    check("post_rst_out_idle", inv_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
